// File: rtl/mixcol_engine.sv
// mixcol_engine: iterative AES (Inv)MixColumns engine.
//   Accepts one 128-bit state on in_valid && in_ready. Over 4/NCOL BUSY
//   cycles it transforms NCOL columns per cycle in place, then holds the
//   result in DONE until out_ready. Bypass runs the same schedule but
//   writes the columns back unchanged.
// Ports:
//   clk, rst (async, active high)
//   in_valid/in_ready/in_state/in_inv/in_bypass : input handshake and data
//   out_valid/out_ready/out_state               : output handshake and data
// Layout: column c is bits [127-32c -: 32]; row 0 is the MSB byte.
// Build option: define MIXCOL_FWD_EN to build the forward datapath too
//   (in_inv then selects). Without it only the inverse is built and
//   in_inv is ignored.
//
// state | meaning
// IDLE  | waiting for a state, in_ready=1
// BUSY  | transforming NCOL columns per cycle
// DONE  | result valid, waiting for out_ready
module mixcol_engine #(
  parameter int NCOL   = 1,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_state,
  input  logic              in_inv,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_state
);

  if (DATA_W != 128) begin : g_bad_width
    $error("mixcol_engine: DATA_W must be 128");
  end
  if (NCOL != 1 && NCOL != 2 && NCOL != 4) begin : g_bad_ncol
    $error("mixcol_engine: NCOL must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(NCOL);
  // Counter value of the final column group; NCOL=4 gives 0 (single pass).
  localparam logic [1:0] LAST = 2'(4 - NCOL);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic                byp_q, byp_d;
  logic                inv_q, inv_d;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] x  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      x[i]  = col[31-8*i -: 8];
      x2    = xt(x[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ x[i];
      mb[i] = x8 ^ x2 ^ x[i];
      md[i] = x8 ^ x4 ^ x[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

`ifdef MIXCOL_FWD_EN
  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a, b, c, d;
    {a, b, c, d} = col;
    return {xt(a) ^ xt(b) ^ b ^ c ^ d,
            a ^ xt(b) ^ xt(c) ^ c ^ d,
            a ^ b ^ xt(c) ^ xt(d) ^ d,
            xt(a) ^ a ^ b ^ c ^ xt(d)};
  endfunction

  function automatic logic [31:0] col_xform(input logic [31:0] col);
    if (byp_q)      return col;
    else if (inv_q) return mix_inv(col);
    else            return mix_fwd(col);
  endfunction

  assign inv_d = (state_q == IDLE && in_valid) ? in_inv : inv_q;
`else
  function automatic logic [31:0] col_xform(input logic [31:0] col);
    if (byp_q) return col;
    else       return mix_inv(col);
  endfunction

  // Inverse-only build: the direction input has no effect.
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign inv_d = 1'b1;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_state = work_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    byp_d   = byp_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          byp_d   = in_bypass;
          cnt_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < NCOL; j++) begin
          int base;
          base = 32 * (3 - int'(cnt_q + 2'(j)));
          work_d[base +: 32] = col_xform(work_q[base +: 32]);
        end
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      work_q  <= '0;
      byp_q   <= 1'b0;
      inv_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      byp_q   <= byp_d;
      inv_q   <= inv_d;
    end
  end

endmodule

// File: tb/tb_mixcol_engine.sv
module tb_mixcol_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid  [3];
  logic         in_inv    [3];
  logic         in_bypass [3];
  logic         out_ready [3];
  logic [127:0] in_state  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic [127:0] out_state [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT 0: NCOL=1, DUT 1: NCOL=2, DUT 2: NCOL=4
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mixcol_engine #(.NCOL(g == 0 ? 1 : (g == 1 ? 2 : 4)), .DATA_W(128)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .in_inv    (in_inv[g]),
      .in_bypass (in_bypass[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g])
    );
  end

  function automatic int ncol_of(int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  // Generic GF(2^8) shift-and-add multiply, modulus 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] st, input logic inv,
                                          input logic byp);
    logic [7:0] fwd_c [4];
    logic [7:0] inv_c [4];
    logic [7:0] coef;
    logic [7:0] acc;
    logic [127:0] r;
    logic use_inv;
    fwd_c = '{8'h02, 8'h03, 8'h01, 8'h01};
    inv_c = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
`ifdef MIXCOL_FWD_EN
    use_inv = inv;
`else
    use_inv = 1'b1;
`endif
    if (byp) return st;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          coef = use_inv ? inv_c[(k - row + 4) % 4] : fwd_c[(k - row + 4) % 4];
          acc  = acc ^ gmul(coef, st[127 - 32*c - 8*k -: 8]);
        end
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  // One transaction: push expectation, wait for output, check latency,
  // optionally hold out_ready low for 'hold' cycles, then release.
  task automatic run_one(input int d, input logic [127:0] st, input logic inv,
                         input logic byp, input int hold, output logic [127:0] obs);
    int lat;
    int lat_exp;
    logic [127:0] exp_v;
    lat_exp = 4 / ncol_of(d) + 1;
    @(negedge clk);
    checks++;
    if (in_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_idle dut%0d: got %b want 1", d, in_ready[d]);
    end
    in_valid[d]  = 1'b1;
    in_state[d]  = st;
    in_inv[d]    = inv;
    in_bypass[d] = byp;
    out_ready[d] = (hold == 0);
    exp_q.push_back(model(st, inv, byp));
    @(posedge clk);
    #1;
    in_valid[d]  = 1'b0;
    in_state[d]  = $urandom();
    in_inv[d]    = ~inv;
    in_bypass[d] = ~byp;
    lat = 1;
    while (out_valid[d] !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != lat_exp) begin
      errors++;
      $display("FAIL latency dut%0d: got %0d want %0d", d, lat, lat_exp);
    end
    exp_v = exp_q.pop_front();
    obs = out_state[d];
    checks++;
    if (out_state[d] !== exp_v) begin
      errors++;
      $display("FAIL result dut%0d: got %h want %h", d, out_state[d], exp_v);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid[d] !== 1'b1 || out_state[d] !== exp_v || in_ready[d] !== 1'b0) begin
        errors++;
        $display("FAIL hold dut%0d cyc%0d: got v=%b r=%b %h want v=1 r=0 %h",
                 d, h, out_valid[d], in_ready[d], out_state[d], exp_v);
      end
      if (h == hold - 1) begin
        @(negedge clk);
        out_ready[d] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_state[d] !== exp_v) begin
      errors++;
      $display("FAIL back_to_idle dut%0d: got r=%b v=%b %h want r=1 v=0 %h",
               d, in_ready[d], out_valid[d], out_state[d], exp_v);
    end
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_state[d] !== '0) begin
        errors++;
        $display("FAIL reset dut%0d: got r=%b v=%b %h want r=1 v=0 0",
                 d, in_ready[d], out_valid[d], out_state[d]);
      end
    end
  endtask

  task automatic test_fwd_vector();
    logic [127:0] obs;
    run_one(0, {4{32'hdb135345}}, 1'b0, 1'b0, 0, obs);
`ifdef MIXCOL_FWD_EN
    checks++;
    if (obs !== {4{32'h8e4da1bc}}) begin
      errors++;
      $display("FAIL fwd_vector: got %h want %h", obs, {4{32'h8e4da1bc}});
    end
`endif
  endtask

  task automatic test_inv_vector();
    logic [127:0] obs;
    run_one(2, {4{32'h8e4da1bc}}, 1'b1, 1'b0, 0, obs);
    checks++;
    if (obs !== {4{32'hdb135345}}) begin
      errors++;
      $display("FAIL inv_vector: got %h want %h", obs, {4{32'hdb135345}});
    end
    run_one(2, {32'h9fdc589d, 32'h01020304, 32'hc6c6c6c6, 32'hdeadbeef}, 1'b1, 1'b0, 0, obs);
    checks++;
    if (obs[127:96] !== 32'hf20a225c) begin
      errors++;
      $display("FAIL inv_col: got %h want f20a225c", obs[127:96]);
    end
  endtask

  task automatic test_bypass();
    logic [127:0] st;
    logic [127:0] obs;
    st = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_one(1, st, 1'b1, 1'b1, 0, obs);
    checks++;
    if (obs !== st) begin
      errors++;
      $display("FAIL bypass: got %h want %h", obs, st);
    end
  endtask

  task automatic test_hold();
    logic [127:0] obs;
    run_one(1, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0, 10, obs);
  endtask

  task automatic test_fixed_points();
    logic [127:0] st;
    logic [127:0] obs;
    st = {32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6, 32'h01010101};
    run_one(2, st, 1'b0, 1'b0, 0, obs);
    checks++;
    if (obs !== st) begin
      errors++;
      $display("FAIL fixed_points: got %h want %h", obs, st);
    end
  endtask

  task automatic test_random();
    logic [127:0] obs;
    for (int i = 0; i < 9; i++) begin
      run_one(i % 3, {$urandom(), $urandom(), $urandom(), $urandom()},
              1'($urandom_range(0, 1)), (i == 4), i % 2, obs);
    end
  endtask

  task automatic test_reset_midbusy();
    logic [127:0] st;
    int seen;
    st = {4{32'h12345678}};
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_state[0] = st;
    in_inv[0]   = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);           // accept
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);           // now in second BUSY cycle
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || out_state[0] !== '0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_midbusy: got v=%b r=%b %h want v=0 r=1 0",
               out_valid[0], in_ready[0], out_state[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || out_state[0] !== '0) begin
      errors++;
      $display("FAIL no_output_after_reset: got pulses=%0d %h want 0 0", seen, out_state[0]);
    end
    out_ready[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    int last_acc;
    int wait_n;
    logic [127:0] exp_v;
    logic [127:0] st;
    out_ready[1] = 1'b1;
    in_inv[1]    = 1'b1;
    in_bypass[1] = 1'b0;
    last_acc = -1;
    @(negedge clk);
    in_valid[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_state[1] = st;
      wait_n = 0;
      while (in_ready[1] !== 1'b1 && wait_n < 20) begin
        @(negedge clk);
        wait_n++;
      end
      exp_q.push_back(model(st, 1'b1, 1'b0));
      if (last_acc >= 0) begin
        checks++;
        if (cyc - last_acc != 4) begin
          errors++;
          $display("FAIL b2b_spacing: got %0d want 4", cyc - last_acc);
        end
      end
      last_acc = cyc;
      @(negedge clk);
      wait_n = 0;
      while (out_valid[1] !== 1'b1 && wait_n < 20) begin
        @(negedge clk);
        wait_n++;
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (out_state[1] !== exp_v || in_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_result %0d: got %h r=%b want %h r=0", i, out_state[1],
                 in_ready[1], exp_v);
      end
      @(negedge clk);
    end
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_inv[d]    = 1'b0;
      in_bypass[d] = 1'b0;
      out_ready[d] = 1'b0;
      in_state[d]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_fwd_vector();
    test_inv_vector();
    test_bypass();
    test_hold();
    test_fixed_points();
    test_random();
    test_back_to_back();
    test_reset_midbusy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mixcol_engine.md
MIXCOL_ENGINE -- requirements
Module: mixcol_engine

Interface
REQ-001 SHALL have parameter NCOL, default 1, giving the number of 32-bit columns processed per cycle; legal values are 1, 2 and 4.
REQ-002 SHALL have parameter DATA_W, default 128, giving the state width; it is fixed at 128 and any other value is a configuration error.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the input state is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the engine accepts a state.
REQ-007 SHALL have port in_state, input, 128 bits: column c is bits [127-32c -: 32], and row 0 is the MSB byte of each column.
REQ-008 SHALL have port in_inv, input, 1 bit: 1 selects InvMixColumns, 0 selects forward MixColumns.
REQ-009 SHALL have port in_bypass, input, 1 bit: the state passes through unchanged (used for the final round).
REQ-010 SHALL have port out_valid, output, 1 bit: out_state holds a result.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-012 SHALL have port out_state, output, 128 bits: the result, in the same layout as in_state.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, BUSY and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-014 SHALL, in IDLE on in_valid&&in_ready, capture in_state, in_inv and in_bypass into internal registers, clear the column counter to 0 and go to BUSY.
REQ-015 SHALL, in BUSY, transform NCOL columns per cycle starting at the counter column, write the results back into the working register, and advance the counter by NCOL, wrapping modulo 4.
REQ-016 SHALL go from BUSY to DONE in the cycle in which the last column group is written, so that BUSY lasts exactly 4/NCOL cycles.
REQ-017 SHALL give a latency from the accept edge to out_valid high of 4/NCOL+1 cycles (2, 3 or 5), independent of the data, in_inv and in_bypass values.
REQ-018 SHALL, in DONE, hold out_state and out_valid stable until out_ready=1, then return to IDLE on that edge.
REQ-019 SHALL NOT accept a new input in the DONE-to-IDLE handover cycle; the maximum throughput is one state per 4/NCOL+2 cycles.
REQ-020 SHALL compute the forward transform per column as s0'=2a^3b^c^d, s1'=a^2b^3c^d, s2'=a^b^2c^3d and s3'=3a^b^c^2d, over GF(2^8) modulo 0x11B.
REQ-021 SHALL compute the inverse transform per column as s0'=Ea^Bb^Dc^9d, s1'=9a^Eb^Bc^Dd, s2'=Da^9b^Ec^Bd and s3'=Ba^Db^9c^Ed.
REQ-022 SHALL, when the captured bypass is 1, still run the BUSY cycles but write columns back unchanged; bypass overrides in_inv.
REQ-023 SHALL ignore in_state, in_inv and in_bypass when in_ready=0, and SHALL ignore out_ready outside DONE.
REQ-024 SHALL drive out_state from the working register, which holds the last result until the next accept.

Reset
REQ-025 SHALL, on rst asserted at any time including mid-BUSY, immediately force the FSM to IDLE, the counter to 0, the working register to 0, out_valid to 0 and in_ready to 1 (the latter after the next edge at the latest, combinationally from IDLE).
REQ-026 SHALL discard any in-flight state on reset and produce no out_valid pulse for it.

Configuration
REQ-027 SHALL use macro MIXCOL_FWD_EN: when it is defined, forward and inverse datapaths are both built and in_inv selects between them.
REQ-028 SHALL, when MIXCOL_FWD_EN is not defined, build only the inverse datapath; in_inv is ignored and is always treated as 1, while latency and handshake are unchanged.

Verification
REQ-029 SHALL be verified with NCOL=1, MIXCOL_FWD_EN defined, in_inv=0 and all columns db135345 -> every out column 8e4da1bc, with out_valid 5 cycles after accept.
REQ-030 SHALL be verified with NCOL=4, in_inv=1 and all columns 8e4da1bc -> every column db135345 with latency 2; also, for one column 9fdc589d, the inverse gives f20a225c.
REQ-031 SHALL be verified with NCOL=2, in_bypass=1 and in_inv=1 on an arbitrary state -> out_state equals in_state after 3 cycles.
REQ-032 SHALL be verified with out_ready held 0 for 10 cycles -> out_state and out_valid stable and in_ready=0 throughout, then out_ready=1 -> IDLE next edge.
REQ-033 SHALL be verified with rst pulsed in the second BUSY cycle (NCOL=1) -> out_valid=0, out_state=0, in_ready=1, and no later output pulse.
REQ-034 SHALL be verified without MIXCOL_FWD_EN, in_inv=0 and columns c6c6c6c6 / 01010101 -> outputs equal inputs (inverse applied; both transforms are fixed points for these columns).
